delay_timer_bank: RTL
=====================

# delay_timer_bank

Bank of `NCH` independent programmable delay timers. It is the parametrised successor of the single fixed-period delay counter. Each channel counts to its own runtime-loaded period and emits a one-cycle `sig` pulse at the end of the period. Each channel runs periodic or one-shot and has start/stop control. The block sits beside control FSMs that need timeouts and ticks, and exports per-channel `flg` (counting) and `err` (invariant violation) for formal checking.

## Interface
- `NCH`, 4: number of channels, ≥1
- `CBITS`, 14: counter/period width
- `N_DEF`, 10000: period loaded into every channel at reset; must fit in `CBITS`
- `CHW`, `$clog2(NCH)` (min 1): channel index width, derived

- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset; asynchronous, active-low
- `cfg_we`  in  1  write period/mode for channel `cfg_ch`
- `cfg_ch`  in  CHW  target channel; values ≥ NCH ignored
- `cfg_period`  in  CBITS  new period P
- `cfg_oneshot`  in  1  1 = one-shot, 0 = periodic
- `start`  in  NCH  per-channel start request
- `stop`  in  NCH  per-channel stop request
- `sig`  out  NCH  one-cycle terminal pulse
- `flg`  out  NCH  1 while channel in RUN
- `err`  out  NCH  sticky: counter exceeded active period
- `busy`  out  1  OR of `flg`

## Operation
- Per channel state: IDLE, RUN. Registers: `cnt[CBITS]`, active period `P_a`, active mode `M_a`, shadow period `P_s`, shadow mode `M_s`, and a pending bit.
- Reset (`rst`=0): all channels IDLE, `cnt`=0, `P_a`=`P_s`=`N_DEF`, `M_a`=`M_s`=periodic, pending=0. All outputs 0.
- Config write to an IDLE channel updates `P_a`/`M_a` and `P_s`/`M_s` at the same edge.
- Config write to a RUN channel updates `P_s`/`M_s` and sets pending. The shadow copies into `P_a`/`M_a` at the next wrap or the next start, and pending clears.
- IDLE + `start`: go to RUN, `cnt`=0.
- RUN, `cnt` < `P_a`: `cnt`+1.
- RUN, `cnt` == `P_a`: `sig`=1 at this edge's output. Periodic: `cnt`=0, stay RUN. One-shot: go to IDLE, `cnt`=0.
- RUN + `start` (and no `stop`): restart, `cnt`=0, no `sig`, pending shadow applied.
- `stop` in any state: go to IDLE, `cnt`=0, no `sig`. `stop` wins over `start` and over a terminal count in the same cycle.
- `err[i]` sets when a RUN channel has `cnt` > `P_a`. It stays set until reset or a config write to channel i. Correct RTL never sets it; the formal property is "after the first cycle, `err` is always 0".
- P=0 is legal. Periodic mode then gives `sig`=1 every cycle. `cnt` never exceeds `P_a`, so there is no overflow, including at P=2^CBITS−1.
- A config write and `start` on the same channel in the same cycle: the new value is used for that run.

## Timing
- All outputs are registered.
- `start` sampled at edge t: `flg`=1 from t+1 and `cnt`=0 at t+1.
- First `sig` is high in the cycle after edge t+1+P_a, i.e. P_a+1 cycles after `flg` rises.
- Periodic mode: `sig` repeats every P_a+1 cycles.
- One-shot mode: `flg` falls in the same cycle `sig` is high.
- `stop` at edge t: `flg`=0 from t+1. Any `sig` scheduled for that edge is suppressed.
- Reset assertion mid-run clears `cnt`, `sig`, `flg`, `err` and `busy` immediately, without waiting for a clock edge. The first `start` is accepted at the first edge after release.
- Channels are fully independent. Simultaneous events on different channels do not interact.

## Test plan
- Reset: hold `rst`=0, drive random inputs → `sig`/`flg`/`err`/`busy`=0. After release, `start[0]` with default `N_DEF`=10000 → `sig[0]` pulses every 10001 cycles.
- Periodic, ch1, P=3: start at edge 0 → `sig[1]` high in cycles 5, 9, 13; `flg[1]` high from cycle 1. With P=0 → `sig[1]` high every cycle from cycle 2.
- One-shot, ch2, P=5: start → single `sig[2]` 6 cycles after `flg[2]` rises, `flg[2]` falls with it. `busy` then 0. A second `start` repeats the run.
- Mid-run reprogram, ch0 periodic P=10: at `cnt`=4 write P=2 → current period completes at 10. Following pulses every 3 cycles. `err` stays 0 throughout.
- Conflicts: `stop[3]` and `start[3]` in the same cycle → IDLE. `stop` exactly at terminal count → no `sig`. `start` while running → `cnt` restarts at 0, next `sig` P+1 cycles later.
- Async reset asserted between clock edges mid-count on all channels → outputs drop before the next edge. After release, all periods are back to `N_DEF` and the mode is periodic.

Source files
------------

// File: rtl/delay_timer_bank.sv
// Bank of NCH independent programmable delay timers. Each channel counts up to its
// own period and pulses sig for one cycle, in either periodic or one-shot mode.
module delay_timer_bank #(
  parameter int NCH   = 4,
  parameter int CBITS = 14,
  parameter int N_DEF = 10000,
  parameter int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [CBITS-1:0] cfg_period,
  input  logic             cfg_oneshot,
  input  logic [NCH-1:0]   start,
  input  logic [NCH-1:0]   stop,
  output logic [NCH-1:0]   sig,
  output logic [NCH-1:0]   flg,
  output logic [NCH-1:0]   err,
  output logic             busy
);

  // state   | meaning
  // IDLE    | channel halted, cnt held at 0
  // RUN     | counting 0..P_a, pulse sig on the edge after cnt == P_a
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [NCH-1:0]   state;
  logic [CBITS-1:0] cnt [NCH];
  logic [CBITS-1:0] p_a [NCH];
  logic [CBITS-1:0] p_s [NCH];
  logic [NCH-1:0]   m_a, m_s, pend;
  logic [NCH-1:0]   wr, tc, apply, run_nxt;

  assign flg = state;

  always_comb begin
    wr      = '0;
    tc      = '0;
    apply   = '0;
    run_nxt = '0;
    for (int i = 0; i < NCH; i++) begin
      wr[i]    = cfg_we && (cfg_ch == CHW'(i));
      tc[i]    = (state[i] == ST_RUN) && (cnt[i] == p_a[i]);
      // The shadow config becomes active at a wrap or a (re)start; stop cancels both.
      apply[i] = !stop[i] && (start[i] || tc[i]);
      if (stop[i])
        run_nxt[i] = ST_IDLE;
      else if (start[i])
        run_nxt[i] = ST_RUN;
      else if (tc[i] && m_a[i])
        run_nxt[i] = ST_IDLE;
      else
        run_nxt[i] = state[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= '0;
      sig   <= '0;
      err   <= '0;
      busy  <= 1'b0;
      m_a   <= '0;
      m_s   <= '0;
      pend  <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
        p_a[i] <= CBITS'(N_DEF);
        p_s[i] <= CBITS'(N_DEF);
      end
    end else begin
      state <= run_nxt;
      busy  <= |run_nxt;
      sig   <= tc & ~start & ~stop;
      for (int i = 0; i < NCH; i++) begin
        if (stop[i] || start[i] || tc[i])
          cnt[i] <= '0;
        else if (state[i] == ST_RUN)
          cnt[i] <= cnt[i] + CBITS'(1);

        // A write that coincides with a start or wrap takes effect for the coming run.
        if (wr[i]) begin
          p_s[i] <= cfg_period;
          m_s[i] <= cfg_oneshot;
          if ((state[i] == ST_IDLE) || apply[i]) begin
            p_a[i]  <= cfg_period;
            m_a[i]  <= cfg_oneshot;
            pend[i] <= 1'b0;
          end else begin
            pend[i] <= 1'b1;
          end
        end else if (apply[i] && pend[i]) begin
          p_a[i]  <= p_s[i];
          m_a[i]  <= m_s[i];
          pend[i] <= 1'b0;
        end

        if (wr[i])
          err[i] <= 1'b0;
        else if ((state[i] == ST_RUN) && (cnt[i] > p_a[i]))
          err[i] <= 1'b1;
      end
    end
  end

endmodule
